alu_74181_dual_top: RTL and testbench

// - Wraps two independent implementations of the 74181 4-bit ALU (active-high data convention) driven by the same inputs.
// - Path "comb" is a behavioural adder/logic model. Path "4bit" is a gate-level carry-lookahead model.
// - Both result sets are registered and exposed side by side, so the two implementations can be cross-checked.

---
 rtl/alu_74181_pkg.sv | 19 +
 rtl/alu_74181_cla.sv | 39 +++
 rtl/alu_74181_dual_top.sv | 129 ++++++++++++
 tb/tb_alu_74181_dual_top.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/alu_74181_pkg.sv
// Shared constants for the dual-implementation 74181 ALU.
// Optional cross-check output is enabled by defining ALU_XCHECK_EN.
package alu_74181_pkg;

    localparam int ALU_W = 4;

    localparam logic M_ARITH = 1'b0;
    localparam logic M_LOGIC = 1'b1;

    // Function selects; SUB and XOR share an encoding and differ only by M.
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_DEC = 4'b1111;
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_DBL = 4'b1100;

    localparam logic [3:0] F_RESET = 4'b0000;

endpackage

// File: rtl/alu_74181_cla.sv
// Gate-level 74181 datapath: per-bit X/Y terms with explicit lookahead carries.
// Purely combinational; registered by alu_74181_dual_top.
module alu_74181_cla
    import alu_74181_pkg::*;
(
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    input  logic [3:0]       i_s,
    input  logic             i_m,
    input  logic             i_cn,
    output logic [ALU_W-1:0] o_f,
    output logic             o_p,
    output logic             o_g
);

    logic [ALU_W-1:0] w_x;
    logic [ALU_W-1:0] w_y;
    logic [ALU_W-1:0] w_h;
    logic [ALU_W-1:0] w_c;

    assign w_x = i_a | (i_b & {ALU_W{i_s[0]}}) | (~i_b & {ALU_W{i_s[1]}});
    assign w_y = (i_a & i_b & {ALU_W{i_s[3]}}) | (i_a & ~i_b & {ALU_W{i_s[2]}});
    assign w_h = w_x ^ w_y;

    // Y implies X, so each stage generates on Y and propagates on X.
    assign w_c[0] = ~i_cn;
    assign w_c[1] = w_y[0] | (w_x[0] & w_c[0]);
    assign w_c[2] = w_y[1] | (w_x[1] & w_y[0]) | (w_x[1] & w_x[0] & w_c[0]);
    assign w_c[3] = w_y[2] | (w_x[2] & w_y[1]) | (w_x[2] & w_x[1] & w_y[0])
                  | (w_x[2] & w_x[1] & w_x[0] & w_c[0]);

    // Logic mode forces the carry term high, turning the sum into ~(X^Y).
    assign o_f = w_h ^ (w_c | {ALU_W{i_m}});

    assign o_p = ~(&w_x);
    assign o_g = ~(w_y[3] | (w_x[3] & w_y[2]) | (w_x[3] & w_x[2] & w_y[1])
                 | (w_x[3] & w_x[2] & w_x[1] & w_y[0]));

endmodule

// File: rtl/alu_74181_dual_top.sv
// Two 74181 implementations (behavioural and gate-level) with registered outputs.
// Define ALU_XCHECK_EN to add the registered xcheck_err disagreement flag.
module alu_74181_dual_top
    import alu_74181_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] A,
    input  logic [ALU_W-1:0] B,
    input  logic [3:0]       S,
    input  logic             M,
    input  logic             Cn,
    output logic [ALU_W-1:0] F_comb,
    output logic             P_comb,
    output logic             G_comb,
    output logic             Cn_out_comb,
    output logic             A_eq_B_comb,
    output logic [ALU_W-1:0] F_4bit,
    output logic             P_4bit,
    output logic             G_4bit,
    output logic             A_eq_B_4bit
`ifdef ALU_XCHECK_EN
    ,
    output logic             xcheck_err
`endif
);

    logic [ALU_W-1:0] w_x;
    logic [ALU_W-1:0] w_y;
    logic [ALU_W:0]   w_sum;
    logic [ALU_W-1:0] w_f_comb;
    logic             w_p_comb;
    logic             w_g_comb;
    logic [ALU_W-1:0] w_f_4bit;
    logic             w_p_4bit;
    logic             w_g_4bit;

    logic [ALU_W-1:0] r_f_comb;
    logic             r_p_comb;
    logic             r_g_comb;
    logic             r_cn_out_comb;
    logic             r_aeqb_comb;
    logic [ALU_W-1:0] r_f_4bit;
    logic             r_p_4bit;
    logic             r_g_4bit;
    logic             r_aeqb_4bit;

    // Behavioural path: plain addition of the per-bit X/Y terms.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int i = 0; i < ALU_W; i++) begin
            w_x[i] = A[i] | (B[i] & S[0]) | (~B[i] & S[1]);
            w_y[i] = (A[i] & B[i] & S[3]) | (A[i] & ~B[i] & S[2]);
        end
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'b0000, ~Cn};
        if (M == M_LOGIC) begin
            w_f_comb = ~(w_x ^ w_y);
        end else begin
            w_f_comb = w_sum[ALU_W-1:0];
        end
        w_p_comb = ~(&w_x);
        w_g_comb = ~(w_y[3] | (w_x[3] & w_y[2]) | (&w_x[3:2] & w_y[1])
                   | (&w_x[3:1] & w_y[0]));
    end

    alu_74181_cla u_cla (
        .i_a  (A),
        .i_b  (B),
        .i_s  (S),
        .i_m  (M),
        .i_cn (Cn),
        .o_f  (w_f_4bit),
        .o_p  (w_p_4bit),
        .o_g  (w_g_4bit)
    );

    // Output registers for both paths; flags reset to their inactive levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_comb      <= F_RESET;
            r_p_comb      <= 1'b1;
            r_g_comb      <= 1'b1;
            r_cn_out_comb <= 1'b1;
            r_aeqb_comb   <= 1'b0;
            r_f_4bit      <= F_RESET;
            r_p_4bit      <= 1'b1;
            r_g_4bit      <= 1'b1;
            r_aeqb_4bit   <= 1'b0;
        end else begin
            r_f_comb      <= w_f_comb;
            r_p_comb      <= w_p_comb;
            r_g_comb      <= w_g_comb;
            r_cn_out_comb <= ~w_sum[ALU_W];
            r_aeqb_comb   <= &w_f_comb;
            r_f_4bit      <= w_f_4bit;
            r_p_4bit      <= w_p_4bit;
            r_g_4bit      <= w_g_4bit;
            r_aeqb_4bit   <= &w_f_4bit;
        end
    end

    assign F_comb      = r_f_comb;
    assign P_comb      = r_p_comb;
    assign G_comb      = r_g_comb;
    assign Cn_out_comb = r_cn_out_comb;
    assign A_eq_B_comb = r_aeqb_comb;
    assign F_4bit      = r_f_4bit;
    assign P_4bit      = r_p_4bit;
    assign G_4bit      = r_g_4bit;
    assign A_eq_B_4bit = r_aeqb_4bit;

`ifdef ALU_XCHECK_EN
    logic r_xcheck_err;

    // Flags a disagreement for the same input vector the outputs belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xcheck_err <= 1'b0;
        end else begin
            r_xcheck_err <= ({w_f_comb, w_p_comb, w_g_comb, &w_f_comb} !=
                             {w_f_4bit, w_p_4bit, w_g_4bit, &w_f_4bit});
        end
    end

    assign xcheck_err = r_xcheck_err;
`endif

endmodule

// File: tb/tb_alu_74181_dual_top.sv
// Self-checking bench for alu_74181_dual_top: directed, random and exhaustive vectors.
// Checks xcheck_err as well when ALU_XCHECK_EN is defined.
module tb_alu_74181_dual_top;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] A, B, S;
    logic       M, Cn;
    logic [3:0] F_comb, F_4bit;
    logic       P_comb, G_comb, Cn_out_comb, A_eq_B_comb;
    logic       P_4bit, G_4bit, A_eq_B_4bit;
`ifdef ALU_XCHECK_EN
    logic       xcheck_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_74181_dual_top dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .A           (A),
        .B           (B),
        .S           (S),
        .M           (M),
        .Cn          (Cn),
        .F_comb      (F_comb),
        .P_comb      (P_comb),
        .G_comb      (G_comb),
        .Cn_out_comb (Cn_out_comb),
        .A_eq_B_comb (A_eq_B_comb),
        .F_4bit      (F_4bit),
        .P_4bit      (P_4bit),
        .G_4bit      (G_4bit),
        .A_eq_B_4bit (A_eq_B_4bit)
`ifdef ALU_XCHECK_EN
        ,
        .xcheck_err  (xcheck_err)
`endif
    );

    // Reference: returns {F, P, G, Cn_out, A_eq_B} from the datasheet rules.
    function automatic logic [7:0] ref_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s, input logic m,
                                             input logic cn);
        int x, y, sum;
        logic [3:0] f;
        logic p, g, co, all_hi;
        x = 0;
        y = 0;
        for (int i = 0; i < 4; i++) begin
            if (a[i] || (b[i] && s[0]) || (!b[i] && s[1])) x += (1 << i);
            if ((a[i] && b[i] && s[3]) || (a[i] && !b[i] && s[2])) y += (1 << i);
        end
        sum = x + y + (cn ? 0 : 1);
        co = (sum >= 16) ? 1'b0 : 1'b1;
        if (m) f = 4'((x ^ y) ^ 15);
        else   f = 4'(sum % 16);
        p = (x == 15) ? 1'b0 : 1'b1;
        g = 1'b1;
        for (int i = 0; i < 4; i++) begin
            all_hi = 1'b1;
            for (int j = i + 1; j < 4; j++) if (((x >> j) & 1) == 0) all_hi = 1'b0;
            if ((((y >> i) & 1) == 1) && all_hi) g = 1'b0;
        end
        return {f, p, g, co, (f == 4'b1111)};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_comb"}, {F_comb, P_comb, G_comb, Cn_out_comb, A_eq_B_comb}, 8'b0000_1110);
        chk({tag, "_4bit"}, {1'b0, F_4bit, P_4bit, G_4bit, A_eq_B_4bit}, 8'b0_0000_110);
`ifdef ALU_XCHECK_EN
        chk({tag, "_xchk"}, {7'd0, xcheck_err}, 8'd0);
`endif
    endtask

    // Drive one vector between edges, then check both paths one edge later.
    task automatic step(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s,
                        input logic m, input logic cn, input string tag);
        logic [7:0] e, mask;
        @(negedge clk);
        A = a; B = b; S = s; M = m; Cn = cn;
        @(posedge clk);
        #1;
        e    = ref_model(a, b, s, m, cn);
        mask = m ? 8'b1111_1101 : 8'b1111_1111;
        chk({tag, "_comb"}, {F_comb, P_comb, G_comb, Cn_out_comb, A_eq_B_comb} & mask, e & mask);
        chk({tag, "_4bit"}, {1'b0, F_4bit, P_4bit, G_4bit, A_eq_B_4bit}, {1'b0, e[7:2], e[0]});
`ifdef ALU_XCHECK_EN
        chk({tag, "_xchk"}, {7'd0, xcheck_err}, 8'd0);
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        A = 4'b1010; B = 4'b0101; S = 4'b1001; M = 1'b0; Cn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");

        @(negedge clk);
        rst_n = 1'b1;

        step(4'b0011, 4'b0101, 4'b1001, 1'b0, 1'b1, "add");
        chk("add_const", {F_comb, F_4bit}, 8'b1000_1000);
        chk("add_flags", {5'd0, Cn_out_comb, P_comb, G_comb}, 8'b0000_0111);

        step(4'b1010, 4'b1100, 4'b0110, 1'b1, 1'b1, "xor");
        chk("xor_const", {F_comb, F_4bit}, 8'b0110_0110);
        chk("xor_aeqb", {6'd0, A_eq_B_comb, A_eq_B_4bit}, 8'd0);

        step(4'b1010, 4'b1010, 4'b1111, 1'b0, 1'b1, "dec");
        chk("dec_const", {F_comb, Cn_out_comb, G_comb, P_comb, 1'b0}, 8'b1001_0000);

        step(4'b1111, 4'b1111, 4'b1100, 1'b0, 1'b1, "dbl");
        chk("dbl_const", {3'd0, F_comb, Cn_out_comb}, 8'b000_1110_0);

        for (int a = 0; a < 16; a += 5) begin
            step(4'(a), 4'(15 - a), 4'b0011, 1'b0, 1'b1, "m1");
            chk("m1_const", {2'd0, F_comb, A_eq_B_comb, A_eq_B_4bit}, 8'b00_1111_11);
        end

        step(4'b1111, 4'b0001, 4'b1001, 1'b0, 1'b1, "wrap");
        chk("wrap_const", {3'd0, F_comb, Cn_out_comb}, 8'b000_0000_0);

        // Reset mid-stream must clear the outputs without waiting for an edge.
        step(4'b0111, 4'b0001, 4'b1001, 1'b0, 1'b0, "pre_rst");
        rst_n = 1'b0;
        #1;
        chk_reset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0010, 4'b0011, 4'b1001, 1'b0, 1'b1, "post_rst");

        for (int n = 0; n < 300; n++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        for (int v = 0; v < 16384; v++) begin
            step(v[3:0], v[7:4], v[11:8], v[12], v[13], "sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
